// File: rtl/dcp_port.sv
// -----------------------------------------------------------------------------
// dcp_port
//   CPU-side register port for the Diagnostic Communication Processor.
//   Sits downstream of dcpctl: an address strobe (mas) latches the register
//   select and cycle direction, and a later data strobe (mds) performs the
//   access. Exposes a DATA register backed by TX/RX FIFOs and a
//   STATUS/CONTROL register, and talks to the DCP engine over valid/ready.
//
// Parameters
//   DEPTH  entries per FIFO (power of 2, >= 2)
//   TMO    max cycles from mas to mds before the cycle is abandoned
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   mas, mds            address / data strobes from dcpctl
//   la1                 register select (0 = DATA, 1 = STATUS/CONTROL)
//   rd                  cycle direction (1 = read), sampled with mas
//   wdata / rdata       CPU write data / registered CPU read data
//   tx_data/valid/ready byte stream toward the DCP engine (TX FIFO head)
//   rx_data/valid/ready byte stream from the DCP engine (into RX FIFO)
//   irq                 registered interrupt request
//
// STATUS layout: [0] rx_nempty [1] rx_full [2] tx_empty [3] tx_full
//                [4] err_ovf   [5] err_tmo [6] irq_en   [7] 0
// -----------------------------------------------------------------------------
module dcp_port #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TMO   = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mas,
    input  logic       mds,
    input  logic       la1,
    input  logic       rd,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       irq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(TMO + 1);

    typedef enum logic {
        IDLE,
        ADDR
    } state_t;

    state_t        state;
    logic          sel;
    logic          dir;
    logic [CW-1:0] cnt;

    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [AW:0]   tx_wp, tx_rp, rx_wp, rx_rp;

    logic          irq_en, err_ovf, err_tmo;

    logic          tx_empty, tx_full, rx_nempty, rx_full;
    logic [7:0]    status;

    logic          tmo_hit, acc;
    logic          rd_data, rd_stat, wr_data, wr_ctrl, flush;
    logic          tx_push, tx_pop, rx_push, rx_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign tx_empty  = (tx_wp == tx_rp);
    assign tx_full   = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign rx_nempty = (rx_wp != rx_rp);
    assign rx_full   = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);

    assign status   = {1'b0, irq_en, err_tmo, err_ovf, tx_full, tx_empty, rx_full, rx_nempty};

    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_mem[tx_rp[AW-1:0]];
    assign rx_ready = ~rx_full;

    always_comb begin
        // mas restarts the cycle; an expired window beats a same-cycle mds,
        // so mds is honoured at most TMO cycles after mas.
        tmo_hit = (state == ADDR) && !mas && (cnt == CW'(TMO));
        acc     = (state == ADDR) && !mas && mds && !tmo_hit;
        rd_data = acc &  dir & ~sel;
        rd_stat = acc &  dir &  sel;
        wr_data = acc & ~dir & ~sel;
        wr_ctrl = acc & ~dir &  sel;
        flush   = wr_ctrl & wdata[2];
        // Full/empty are taken before any same-cycle pop/push.
        tx_push = wr_data & ~tx_full;
        tx_pop  = tx_valid & tx_ready;
        rx_push = rx_valid & rx_ready;
        rx_pop  = rd_data & rx_nempty;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            sel     <= 1'b0;
            dir     <= 1'b0;
            cnt     <= '0;
            tx_wp   <= '0;
            tx_rp   <= '0;
            rx_wp   <= '0;
            rx_rp   <= '0;
            rdata   <= '0;
            irq_en  <= 1'b0;
            err_ovf <= 1'b0;
            err_tmo <= 1'b0;
            irq     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mas) begin
                        state <= ADDR;
                        sel   <= la1;
                        dir   <= rd;
                        cnt   <= '0;
                    end
                end
                ADDR: begin
                    if (mas) begin
                        sel <= la1;
                        dir <= rd;
                        cnt <= '0;
                    end else if (tmo_hit || mds) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase

            // Flush overrides any same-cycle engine push/pop.
            if (flush) begin
                tx_wp <= '0;
                tx_rp <= '0;
                rx_wp <= '0;
                rx_rp <= '0;
            end else begin
                if (tx_push) tx_wp <= tx_wp + (AW+1)'(1);
                if (tx_pop)  tx_rp <= tx_rp + (AW+1)'(1);
                if (rx_push) rx_wp <= rx_wp + (AW+1)'(1);
                if (rx_pop)  rx_rp <= rx_rp + (AW+1)'(1);
            end

            if (rd_data)
                rdata <= rx_nempty ? rx_mem[rx_rp[AW-1:0]] : 8'h00;
            else if (rd_stat)
                rdata <= status;

            if (wr_ctrl)
                irq_en <= wdata[0];

            // Clear first, then set, so a same-cycle set is kept.
            if (wr_ctrl && wdata[1]) begin
                err_ovf <= 1'b0;
                err_tmo <= 1'b0;
            end
            if (wr_data && tx_full)
                err_ovf <= 1'b1;
            if (tmo_hit)
                err_tmo <= 1'b1;

            irq <= irq_en & (rx_nempty | err_ovf | err_tmo);
        end
    end

    // FIFO storage; contents behind the pointers need no reset.
    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            if (tx_push) tx_mem[tx_wp[AW-1:0]] <= wdata;
            if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_data;
        end
    end

endmodule

// File: tb/tb_dcp_port.sv
module tb_dcp_port;

    localparam int DEPTH = 4;
    localparam int TMO   = 15;

    logic       clk = 1'b0;
    logic       reset, mas, mds, la1, rd;
    logic [7:0] wdata, rdata, tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, rx_ready, irq;

    dcp_port #(.DEPTH(DEPTH), .TMO(TMO)) dut (
        .clk(clk), .reset(reset), .mas(mas), .mds(mds), .la1(la1), .rd(rd),
        .wdata(wdata), .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: FIFOs as queues, registers as plain flags.
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    bit         m_irq_en, m_ovf, m_tmo, m_irq, m_pend, m_sel, m_rd;
    int         m_age;
    logic [7:0] m_rdata;

    // Engine-side inputs used by the helper transactions.
    bit         e_txr = 1'b0, e_rxv = 1'b0;
    logic [7:0] e_rxd = 8'h00;
    bit         e_rand = 1'b0;

    typedef struct {
        bit         rd;
        bit         sel;
        logic [7:0] d;
        bit         chk;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        txq.delete();
        rxq.delete();
        m_irq_en = 0; m_ovf = 0; m_tmo = 0; m_irq = 0;
        m_pend = 0; m_sel = 0; m_rd = 0; m_age = 0;
        m_rdata = 8'h00;
    endtask

    task automatic compare_all();
        check("rdata", rdata, m_rdata);
        check("tx_valid", 8'(tx_valid), 8'(txq.size() > 0));
        if (txq.size() > 0) check("tx_data", tx_data, txq[0]);
        check("rx_ready", 8'(rx_ready), 8'(rxq.size() < DEPTH));
        check("irq", 8'(irq), 8'(m_irq));
    endtask

    task automatic do_reset();
        reset = 1; mas = 0; mds = 0; la1 = 0; rd = 0; wdata = 8'h00;
        tx_ready = 0; rx_valid = 0; rx_data = 8'h00;
        @(posedge clk); #1;
        reset = 0;
        model_clear();
        compare_all();
    endtask

    // One clock: drive inputs, advance the model by the rules, then compare.
    task automatic cycle(input bit i_mas, input bit i_mds, input bit i_la1, input bit i_rd,
                         input logic [7:0] i_wd);
        int         txn, rxn;
        bit         acc, nirq, txr, rxv;
        logic [7:0] st, rxd;
        if (e_rand) begin
            txr = ($urandom_range(0, 2) == 0);
            rxv = ($urandom_range(0, 2) == 0);
            rxd = 8'($urandom);
        end else begin
            txr = e_txr; rxv = e_rxv; rxd = e_rxd;
        end
        mas = i_mas; mds = i_mds; la1 = i_la1; rd = i_rd; wdata = i_wd;
        tx_ready = txr; rx_valid = rxv; rx_data = rxd;

        txn  = txq.size();
        rxn  = rxq.size();
        st   = {1'b0, m_irq_en, m_tmo, m_ovf, txn == DEPTH, txn == 0, rxn == DEPTH, rxn != 0};
        nirq = m_irq_en && (rxn != 0 || m_ovf || m_tmo);

        acc = 0;
        if (i_mas) begin
            m_pend = 1; m_age = 0; m_sel = i_la1; m_rd = i_rd;
        end else if (m_pend) begin
            m_age++;
            if (m_age > TMO) begin
                m_tmo  = 1;
                m_pend = 0;
            end else if (i_mds) begin
                acc    = 1;
                m_pend = 0;
            end
        end

        if (acc && !m_rd && m_sel && i_wd[2]) begin
            m_irq_en = i_wd[0];
            if (i_wd[1]) begin m_ovf = 0; m_tmo = 0; end
            txq.delete();
            rxq.delete();
        end else begin
            if (txr && txn > 0) void'(txq.pop_front());
            if (acc) begin
                case ({m_rd, m_sel})
                    2'b10: m_rdata = (rxn > 0) ? rxq.pop_front() : 8'h00;
                    2'b11: m_rdata = st;
                    2'b00: if (txn < DEPTH) txq.push_back(i_wd); else m_ovf = 1;
                    default: begin
                        m_irq_en = i_wd[0];
                        if (i_wd[1]) begin m_ovf = 0; m_tmo = 0; end
                    end
                endcase
            end
            if (rxv && rxn < DEPTH) rxq.push_back(rxd);
        end
        m_irq = nirq;

        @(posedge clk); #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 8'h00);
    endtask

    task automatic cpu_wr(input bit sel, input logic [7:0] d);
        cycle(1, 0, sel, 0, 8'h00);
        cycle(0, 1, sel, 0, d);
    endtask

    task automatic cpu_rd(input bit sel);
        cycle(1, 0, sel, 1, 8'h00);
        cycle(0, 1, sel, 1, 8'h00);
    endtask

    initial begin
        // Test 3 as a table, followed by a flush.
        for (int i = 1; i <= 5; i++) tbl.push_back('{1'b0, 1'b0, 8'(i), 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b1, 8'h00, 1'b1, 8'h18});
        tbl.push_back('{1'b0, 1'b1, 8'h02, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b1, 8'h00, 1'b1, 8'h08});
        tbl.push_back('{1'b0, 1'b1, 8'h04, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b1, 8'h00, 1'b1, 8'h04});

        // 1. Reset state
        do_reset();
        check("t1 irq", 8'(irq), 8'h00);
        check("t1 rx_ready", 8'(rx_ready), 8'h01);
        check("t1 tx_valid", 8'(tx_valid), 8'h00);
        check("t1 rdata", rdata, 8'h00);
        cpu_rd(1);
        check("t1 status", rdata, 8'h04);

        // 2. Two bytes drained by the engine in order
        cpu_wr(0, 8'hA5);
        cpu_wr(0, 8'h3C);
        check("t2 head0", tx_data, 8'hA5);
        e_txr = 1;
        idle(1);
        check("t2 head1", tx_data, 8'h3C);
        idle(1);
        check("t2 drained", 8'(tx_valid), 8'h00);
        e_txr = 0;

        // 3. Overflow and clear (table driven)
        foreach (tbl[i]) begin
            if (tbl[i].rd) cpu_rd(tbl[i].sel);
            else           cpu_wr(tbl[i].sel, tbl[i].d);
            if (tbl[i].chk) check($sformatf("t3 vec%0d", i), rdata, tbl[i].exp);
        end

        // 4. RX fill, interrupt, drain
        e_rxv = 1;
        for (int i = 1; i <= 4; i++) begin
            e_rxd = 8'(8'h11 * i);
            idle(1);
        end
        e_rxv = 0;
        check("t4 rx_ready full", 8'(rx_ready), 8'h00);
        cpu_wr(1, 8'h01);
        idle(1);
        check("t4 irq set", 8'(irq), 8'h01);
        for (int i = 1; i <= 4; i++) begin
            cpu_rd(0);
            check($sformatf("t4 read%0d", i), rdata, 8'(8'h11 * i));
        end
        cpu_rd(0);
        check("t4 read empty", rdata, 8'h00);
        check("t4 irq clear", 8'(irq), 8'h00);
        cpu_wr(1, 8'h00);

        // 5. Timeout window boundaries
        cycle(1, 0, 0, 0, 8'h00);
        idle(TMO - 1);
        cycle(0, 1, 0, 0, 8'h77);       // mds exactly TMO cycles after mas
        check("t5 last-chance push", tx_data, 8'h77);
        check("t5 last-chance valid", 8'(tx_valid), 8'h01);
        cpu_wr(1, 8'h04);
        cycle(1, 0, 0, 0, 8'h00);
        idle(TMO);
        cycle(0, 1, 0, 0, 8'h99);       // one cycle too late
        cycle(0, 1, 0, 0, 8'h99);       // mds in IDLE
        check("t5 no late push", 8'(tx_valid), 8'h00);
        cpu_rd(1);
        check("t5 status tmo", rdata, 8'h24);

        // mas relatch and mas+mds collision: the second mas wins
        cycle(1, 0, 0, 0, 8'h00);
        cycle(1, 1, 1, 1, 8'h00);
        cycle(0, 1, 1, 1, 8'h00);
        check("relatch status", rdata, 8'h24);
        cpu_wr(1, 8'h02);

        // 6. Reset discards a pending access; flush of half-full FIFOs
        cycle(1, 0, 0, 0, 8'h00);
        do_reset();
        cycle(0, 1, 0, 0, 8'h55);
        check("t6 no push", 8'(tx_valid), 8'h00);
        cpu_rd(1);
        check("t6 status", rdata, 8'h04);
        cpu_wr(0, 8'hB1);
        cpu_wr(0, 8'hB2);
        e_rxv = 1; e_rxd = 8'hC1; idle(1);
        e_rxd = 8'hC2; idle(1);
        e_rxv = 0;
        cycle(1, 0, 1, 0, 8'h00);
        e_txr = 1; e_rxv = 1; e_rxd = 8'hEE;
        cycle(0, 1, 1, 0, 8'h04);       // flush against engine push/pop
        e_txr = 0; e_rxv = 0;
        check("t6 tx flushed", 8'(tx_valid), 8'h00);
        check("t6 rx flushed", 8'(rx_ready), 8'h01);
        cpu_rd(1);
        check("t6 status empty", rdata, 8'h04);

        // Randomized transactions against the model
        e_rand = 1;
        for (int n = 0; n < 600; n++) begin
            int         op, gap;
            bit         s, r;
            logic [7:0] d;
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
                continue;
            end
            op  = $urandom_range(0, 9);
            s   = (op >= 6);
            r   = op[0];
            d   = 8'($urandom);
            if (s && !r && $urandom_range(0, 7) != 0) d[2] = 1'b0;
            gap = ($urandom_range(0, 24) == 0) ? TMO + $urandom_range(0, 2)
                                               : $urandom_range(0, 3);
            cycle(1, 0, s, r, 8'h00);
            idle(gap);
            cycle(0, 1, s, r, d);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        e_rand = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
